// File: rtl/mem_arbiter_if.sv
// Signal bundle tying the fetch port, the data port and the unified memory to mem_arbiter.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic [DATA_W-1:0]     if_rdata;
   logic                  if_valid;
   logic                  d_req;
   logic                  d_we;
   logic [DATA_W/8-1:0]   d_be;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_valid;
   logic                  stall_if;
   logic                  stall_mem;
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_be;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_ready;
   logic                  err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the pipelined MIPS core: serialises fetch and data accesses
// onto one unified memory, with a starvation limit for fetches and a per-access timeout.
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_D_RUN = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;
   localparam int RUN_W = $clog2(MAX_D_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);
   localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state_r;
   logic [RUN_W-1:0]  run_cnt_r;
   logic [7:0]        wait_cnt_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [BE_W-1:0]   mem_be_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;
   logic              if_valid_r;
   logic              d_valid_r;
   logic              err_r;
   logic              if_elig_s;
   logic              d_elig_s;
   logic              grant_i_s;
   logic              grant_d_s;

   // Grant selection: data first unless fetch has sat through MAX_D_RUN data grants
   always_comb begin
      if_elig_s = bus.if_req & ~if_valid_r;
      d_elig_s  = bus.d_req & ~d_valid_r;
      if (d_elig_s && !(if_elig_s && (run_cnt_r == RUN_MAX))) begin
         grant_d_s = 1'b1;
         grant_i_s = 1'b0;
      end else if (if_elig_s) begin
         grant_d_s = 1'b0;
         grant_i_s = 1'b1;
      end else begin
         grant_d_s = 1'b0;
         grant_i_s = 1'b0;
      end
   end

   // Access sequencer: issue the grant, wait for mem_ready or timeout, return data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         run_cnt_r   <= {RUN_W{1'b0}};
         wait_cnt_r  <= 8'd0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_be_r    <= {BE_W{1'b0}};
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         if_rdata_r  <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
         if_valid_r  <= 1'b0;
         d_valid_r   <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         if_valid_r <= 1'b0;
         d_valid_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               wait_cnt_r <= 8'd0;
               if (grant_d_s) begin
                  state_r     <= BUSY_D;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= bus.d_we;
                  mem_be_r    <= bus.d_be;
                  mem_addr_r  <= bus.d_addr;
                  mem_wdata_r <= bus.d_wdata;
                  if (!bus.if_req) begin
                     run_cnt_r <= {RUN_W{1'b0}};
                  end else if (run_cnt_r != RUN_MAX) begin
                     run_cnt_r <= run_cnt_r + RUN_W'(1);
                  end else begin
                     run_cnt_r <= run_cnt_r;
                  end
               end else if (grant_i_s) begin
                  state_r     <= BUSY_I;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b0;
                  mem_be_r    <= {BE_W{1'b1}};
                  mem_addr_r  <= bus.if_addr;
                  mem_wdata_r <= {DATA_W{1'b0}};
                  run_cnt_r   <= {RUN_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY_I, BUSY_D: begin
               // A ready on the expiry edge wins over the timeout
               if (bus.mem_ready) begin
                  state_r    <= IDLE;
                  mem_req_r  <= 1'b0;
                  wait_cnt_r <= 8'd0;
                  if (state_r == BUSY_I) begin
                     if_valid_r <= 1'b1;
                     if_rdata_r <= bus.mem_rdata;
                  end else begin
                     d_valid_r <= 1'b1;
                     if (!mem_we_r) begin
                        d_rdata_r <= bus.mem_rdata;
                     end else begin
                        d_rdata_r <= d_rdata_r;
                     end
                  end
               end else if (wait_cnt_r == WAIT_MAX) begin
                  state_r    <= IDLE;
                  mem_req_r  <= 1'b0;
                  wait_cnt_r <= 8'd0;
                  err_r      <= 1'b1;
                  if (state_r == BUSY_I) begin
                     if_valid_r <= 1'b1;
                     if_rdata_r <= {DATA_W{1'b0}};
                  end else begin
                     d_valid_r <= 1'b1;
                     d_rdata_r <= {DATA_W{1'b0}};
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r    <= IDLE;
               mem_req_r  <= 1'b0;
               wait_cnt_r <= 8'd0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_be    = mem_be_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.if_valid  = if_valid_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.d_valid   = d_valid_r;
   assign bus.err       = err_r;
   assign bus.stall_if  = bus.if_req & ~if_valid_r;
   assign bus.stall_mem = bus.d_req & ~d_valid_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single accesses, directed multi-cycle corner
// cases, then randomized traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int TMO    = 8;
   localparam int MAXRUN = 4;
   localparam int NRAND  = 3000;

   typedef struct {
      bit          is_i;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          lat;
      logic        exp_we;
      logic [3:0]  exp_be;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   vec_t tbl [6];

   // reference model: who owns the memory, when it started, and the expected outputs
   int          own;
   int          start_cyc;
   int          runs;
   bit          cur_we;
   logic        m_ifv, m_dv, m_err, m_mreq, m_mwe;
   logic [3:0]  m_mbe;
   logic [31:0] m_maddr, m_mwdata, m_ifr, m_dr;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXRUN), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic model_check();
      chk("rnd if_valid", bus.if_valid, m_ifv);
      chk("rnd d_valid", bus.d_valid, m_dv);
      chk("rnd if_rdata", bus.if_rdata, m_ifr);
      chk("rnd d_rdata", bus.d_rdata, m_dr);
      chk("rnd err", bus.err, m_err);
      chk("rnd mem_req", bus.mem_req, m_mreq);
      chk("rnd mem_addr", bus.mem_addr, m_maddr);
      chk("rnd mem_we", bus.mem_we, m_mwe);
      chk("rnd mem_be", bus.mem_be, m_mbe);
      if (own == 2 && cur_we) chk("rnd mem_wdata", bus.mem_wdata, m_mwdata);
   endtask

   // predicts what the next edge does, from the arbitration and completion rules
   task automatic model_edge();
      bit ie, de, nifv, ndv, abort;
      nifv = 1'b0;
      ndv  = 1'b0;
      if (own != 0) begin
         abort = !bus.mem_ready && (cyc - start_cyc == TMO);
         if (bus.mem_ready || abort) begin
            m_mreq = 1'b0;
            if (own == 1) begin
               nifv  = 1'b1;
               m_ifr = abort ? 32'h0 : bus.mem_rdata;
            end else begin
               ndv = 1'b1;
               if (abort) m_dr = 32'h0;
               else if (!cur_we) m_dr = bus.mem_rdata;
            end
            if (abort) m_err = 1'b1;
            own = 0;
         end
      end else begin
         ie = bus.if_req && !m_ifv;
         de = bus.d_req && !m_dv;
         if (de && !(ie && runs >= MAXRUN)) begin
            own = 2; cur_we = bus.d_we; m_mreq = 1'b1; start_cyc = cyc + 1;
            m_mwe = bus.d_we; m_mbe = bus.d_be; m_maddr = bus.d_addr; m_mwdata = bus.d_wdata;
            runs = bus.if_req ? ((runs < MAXRUN) ? runs + 1 : MAXRUN) : 0;
         end else if (ie) begin
            own = 1; cur_we = 1'b0; m_mreq = 1'b1; start_cyc = cyc + 1;
            m_mwe = 1'b0; m_mbe = 4'hF; m_maddr = bus.if_addr;
            runs = 0;
         end
      end
      m_ifv = nifv;
      m_dv  = ndv;
   endtask

   task automatic drive_random();
      if (!bus.if_req || m_ifv) begin
         bus.if_req  = ($urandom_range(0, 1) == 0);
         bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.d_req || m_dv) begin
         bus.d_req   = ($urandom_range(0, 1) == 0);
         bus.d_we    = $urandom_range(0, 1) == 1;
         bus.d_be    = 4'($urandom);
         bus.d_addr  = $urandom & 32'hFFFF_FFFC;
         bus.d_wdata = $urandom;
      end
      bus.mem_ready = m_mreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      tbl[0] = '{1'b1, 1'b0, 4'hF, 32'h40,  32'h0,        32'h8C010004, 1, 1'b0, 4'hF, 32'h8C010004};
      tbl[1] = '{1'b0, 1'b0, 4'hF, 32'h100, 32'h0,        32'h12345678, 0, 1'b0, 4'hF, 32'h12345678};
      tbl[2] = '{1'b0, 1'b1, 4'h3, 32'h200, 32'hDEADBEEF, 32'hAAAA5555, 2, 1'b1, 4'h3, 32'h12345678};
      tbl[3] = '{1'b1, 1'b0, 4'h0, 32'h44,  32'h0,        32'h27BDFFE8, 3, 1'b0, 4'hF, 32'h27BDFFE8};
      tbl[4] = '{1'b0, 1'b0, 4'h1, 32'h104, 32'h0,        32'hCAFEF00D, 0, 1'b0, 4'h1, 32'hCAFEF00D};
      tbl[5] = '{1'b0, 1'b1, 4'hC, 32'h208, 32'h01020304, 32'h77777777, 1, 1'b1, 4'hC, 32'hCAFEF00D};

      clear_inputs();
      #2;
      do_reset();
      chk("rst mem_req", bus.mem_req, 1'b0);
      chk("rst mem_we", bus.mem_we, 1'b0);
      chk("rst mem_be", bus.mem_be, 4'h0);
      chk("rst mem_addr", bus.mem_addr, 32'h0);
      chk("rst mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst if_rdata", bus.if_rdata, 32'h0);
      chk("rst d_rdata", bus.d_rdata, 32'h0);
      chk("rst if_valid", bus.if_valid, 1'b0);
      chk("rst d_valid", bus.d_valid, 1'b0);
      chk("rst err", bus.err, 1'b0);

      // table of single accesses from idle
      for (int i = 0; i < 6; i++) begin
         clear_inputs();
         if (tbl[i].is_i) begin
            bus.if_req = 1'b1; bus.if_addr = tbl[i].addr;
            bus.d_we = 1'b1; bus.d_be = 4'h5; bus.d_wdata = 32'hBAD0BAD0;
         end else begin
            bus.d_req = 1'b1; bus.d_we = tbl[i].we; bus.d_be = tbl[i].be;
            bus.d_addr = tbl[i].addr; bus.d_wdata = tbl[i].wdata;
         end
         #1;
         chk("tbl stall req", tbl[i].is_i ? bus.stall_if : bus.stall_mem, 1'b1);
         step();
         chk("tbl grant", bus.mem_req, 1'b1);
         chk("tbl mem_addr", bus.mem_addr, tbl[i].addr);
         chk("tbl mem_we", bus.mem_we, tbl[i].exp_we);
         chk("tbl mem_be", bus.mem_be, tbl[i].exp_be);
         if (tbl[i].we) chk("tbl mem_wdata", bus.mem_wdata, tbl[i].wdata);
         for (int k = 0; k < tbl[i].lat; k++) begin
            step();
            chk("tbl hold", bus.mem_req, 1'b1);
            chk("tbl stall wait", tbl[i].is_i ? bus.stall_if : bus.stall_mem, 1'b1);
         end
         bus.mem_ready = 1'b1;
         bus.mem_rdata = tbl[i].mrdata;
         step();
         chk("tbl valid", tbl[i].is_i ? bus.if_valid : bus.d_valid, 1'b1);
         chk("tbl other valid", tbl[i].is_i ? bus.d_valid : bus.if_valid, 1'b0);
         chk("tbl rdata", tbl[i].is_i ? bus.if_rdata : bus.d_rdata, tbl[i].exp_rdata);
         chk("tbl mem_req drop", bus.mem_req, 1'b0);
         chk("tbl stall done", tbl[i].is_i ? bus.stall_if : bus.stall_mem, 1'b0);
         clear_inputs();
         step();
         chk("tbl valid pulse", tbl[i].is_i ? bus.if_valid : bus.d_valid, 1'b0);
      end

      // collision with zero-wait memory: data first, fetch granted in the d_valid cycle
      clear_inputs();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_0000;
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.d_req = 1'b1; bus.d_addr = 32'h100; bus.d_be = 4'hF;
      step();
      chk("col data first", bus.mem_addr, 32'h100);
      chk("col mem_req", bus.mem_req, 1'b1);
      step();
      chk("col d_valid", bus.d_valid, 1'b1);
      chk("col d_rdata", bus.d_rdata, 32'h1111_0000);
      chk("col if_valid early", bus.if_valid, 1'b0);
      bus.d_req = 1'b0; bus.mem_rdata = 32'h2222_0000;
      step();
      chk("col fetch grant", bus.mem_addr, 32'h80);
      chk("col fetch mem_req", bus.mem_req, 1'b1);
      step();
      chk("col if_valid", bus.if_valid, 1'b1);
      chk("col if_rdata", bus.if_rdata, 32'h2222_0000);
      clear_inputs();
      step();

      // mem_ready on the expiry edge completes normally
      bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_be = 4'hF;
      step();
      repeat (TMO) begin
         chk("edge hold", bus.mem_req, 1'b1);
         step();
      end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_0001;
      step();
      chk("edge d_valid", bus.d_valid, 1'b1);
      chk("edge d_rdata", bus.d_rdata, 32'h5A5A_0001);
      chk("edge err", bus.err, 1'b0);
      clear_inputs();
      step();

      // timeout: mem_req high TIMEOUT+1 cycles, then aborted read with sticky err
      bus.d_req = 1'b1; bus.d_addr = 32'h304; bus.d_be = 4'hF;
      step();
      cnt = 0;
      for (int k = 0; k < 40 && bus.mem_req; k++) begin
         cnt++;
         step();
      end
      chk("tmo req cycles", cnt, TMO + 1);
      chk("tmo d_valid", bus.d_valid, 1'b1);
      chk("tmo d_rdata", bus.d_rdata, 32'h0);
      chk("tmo err", bus.err, 1'b1);
      clear_inputs();
      repeat (3) step();
      chk("tmo err sticky", bus.err, 1'b1);

      // reset in the middle of a data access
      bus.d_req = 1'b1; bus.d_addr = 32'h308; bus.d_be = 4'hF;
      step();
      chk("rma busy", bus.mem_req, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rma mem_req", bus.mem_req, 1'b0);
      chk("rma d_valid", bus.d_valid, 1'b0);
      chk("rma err", bus.err, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rma idle", bus.mem_req, 1'b0);
      step();
      chk("rma regrant", bus.mem_req, 1'b1);
      chk("rma regrant addr", bus.mem_addr, 32'h308);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_CAFE;
      step();
      chk("rma d_valid", bus.d_valid, 1'b1);
      chk("rma d_rdata", bus.d_rdata, 32'h0BAD_CAFE);
      clear_inputs();
      step();

      // randomized traffic against the reference model
      do_reset();
      own = 0; start_cyc = 0; runs = 0; cur_we = 1'b0; cyc = 0;
      m_ifv = 1'b0; m_dv = 1'b0; m_err = 1'b0; m_mreq = 1'b0; m_mwe = 1'b0;
      m_mbe = 4'h0; m_maddr = 32'h0; m_mwdata = 32'h0; m_ifr = 32'h0; m_dr = 32'h0;
      for (int n = 0; n < NRAND; n++) begin
         model_check();
         drive_random();
         #1;
         chk("rnd stall_if", bus.stall_if, bus.if_req & ~m_ifv);
         chk("rnd stall_mem", bus.stall_mem, bus.d_req & ~m_dv);
         model_edge();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the pipelined MIPS core. Shares one unified instruction/data memory between the fetch stage (instruction port) and the memory stage (data port). It serialises requests through a three-state FSM, issues registered memory-side handshakes, and returns read data with one-cycle valid pulses. It drives the stall signals the pipeline control uses to freeze the IF and MEM stages while an access is outstanding.

## Interface
- ADDR_W, 32, address width of both ports and the memory bus
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- MAX_D_RUN, 4, consecutive data grants allowed while an instruction request waits
- TIMEOUT, 255, maximum cycles waiting for mem_ready before an access is aborted (1..255)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- if_req  in  1  instruction fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req high
- if_rdata  out  DATA_W  fetched word
- if_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte enables (writes only)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data
- d_valid  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  d_req & ~d_valid
- mem_req  out  1  memory access strobe, held until mem_ready
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered access fields
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_ready  in  1  access complete
- err  out  1  sticky timeout flag, cleared only by reset

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: a port's req is ignored in the cycle its own valid is high. Eligible requests are arbitrated as follows:
  - Data wins, unless if_req is eligible and run_cnt == MAX_D_RUN, in which case instruction wins.
  - Winner's fields are registered onto mem_*; mem_req=1; go to BUSY_D or BUSY_I.
  - For instruction grants, mem_we=0 and mem_be=all ones.
- run_cnt counts consecutive data grants while if_req is high. It resets to 0 on any instruction grant, or on a data grant with if_req low. It saturates at MAX_D_RUN.
- BUSY_x, mem_ready=1:
  - mem_req drops next cycle, x_valid pulses next cycle, state returns to IDLE.
  - Reads capture mem_rdata into x_rdata.
  - Writes leave d_rdata unchanged.
- BUSY_x, no mem_ready: the wait counter increments.
  - At TIMEOUT, the access aborts: mem_req drops, x_valid pulses, x_rdata=0, err sets, state returns to IDLE.
- mem_* fields are stable for the whole BUSY state.
- if_rdata and d_rdata hold their last value between accesses.
- Reset values: state IDLE; mem_req, mem_we, if_valid, d_valid, err = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0; run_cnt and wait counter = 0.

## Timing
- Grant: request seen in IDLE at edge k; mem_req high in cycle k+1.
- Completion: mem_ready sampled high at edge m; x_valid high in cycle m+1 with rdata valid; state IDLE in cycle m+1.
- Minimum latency (mem_ready combinationally high): req at cycle 0, valid at cycle 2. Throughput is one access per 2 cycles.
- Back-to-back: a different port's pending request is granted in the valid cycle of the previous access.
- Simultaneous if_req and d_req in IDLE: data first, instruction next, unless the starvation limit applies.
- Timeout: mem_req falls and valid pulses exactly TIMEOUT+1 cycles after mem_req rose.
- A mem_ready arriving on the same edge as timeout expiry completes normally; err stays 0.
- Reset mid-access: all outputs reach reset values asynchronously, including mem_req=0. There is no valid pulse, and the pending request is re-arbitrated after reset release.
- stall_if and stall_mem are combinational from inputs and valid registers.

## Test plan
- Single fetch: if_req, if_addr=0x40, mem_ready 1 cycle after mem_req with mem_rdata=0x8C010004 -> mem_addr=0x40; if_valid in cycle 3; if_rdata=0x8C010004; stall_if high cycles 0-2.
- Collision: if_req and d_req (read 0x100) both high at cycle 0, memory zero-wait -> data granted first; d_valid cycle 2; instruction granted cycle 2; if_valid cycle 4.
- Starvation: d_req held continuously and if_req high, MAX_D_RUN=4 -> exactly 4 data grants, then one instruction grant, then data resumes.
- Write: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF, d_addr=0x200 -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_valid pulses; d_rdata unchanged.
- Timeout: mem_ready held low, TIMEOUT=8 -> mem_req high 9 cycles, then d_valid with d_rdata=0, err=1 sticky until reset.
- Reset mid-access: assert reset in BUSY_D -> mem_req, d_valid, err = 0 immediately; after release with d_req still high, a new grant occurs one cycle later.
